// File: rtl/cpu_ctrl_pkg.sv
// Opcode values and state encodings shared by the control sequencer and its bench.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_STO = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_MOV = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_ILLEGAL_MIN = 4'd12;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_JUMP   = 4'd6,
    ST_SKIP   = 4'd7,
    ST_DONE   = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

  // Opcodes that fetch an operand from memory and then load the accumulator.
  function automatic logic is_mem_operand(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
           (op == OP_SUB) || (op == OP_OR)  || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts consecutive not-ready cycles of a memory beat and flags a stall.
// Latency: timeout is combinational in the cycle the count reaches WAIT_MAX.
// Backpressure: ready in the timeout cycle wins; WAIT_MAX=0 never times out.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(WAIT_MAX) + 1;

  logic [CW-1:0] wait_cnt;

  generate
    if (WAIT_MAX > 0) begin : g_timer
      localparam logic [CW-1:0] MAX_V = CW'(WAIT_MAX);

      assign timeout = waiting && !ready && (wait_cnt == MAX_V);

      // Clearing on timeout keeps the count bounded by WAIT_MAX.
      always_ff @(posedge clk) begin
        if (rst || !waiting || ready || timeout) begin
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end else begin : g_no_timer
      assign timeout = 1'b0;

      always_ff @(posedge clk) begin
        wait_cnt <= '0;
      end
    end
  endgenerate

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Purpose: variable-length instruction sequencer driving PC/ACC/IR/memory enables.
// Latency: outputs decoded from state (and mem_ready) in the same cycle.
// Backpressure: mem_ready stalls FETCH/MEM_RD/MEM_WR; a stall of WAIT_MAX cycles halts.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = OPCODE_W,
  parameter int FETCH_BEATS = 2,
  parameter int WAIT_MAX    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            resume,
  input  logic [OP_W-1:0] operation,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            fetch,
  output logic            alu_en,
  output logic            pc_inc,
  output logic            rd,
  output logic            wr,
  output logic            load_acc,
  output logic            load_ir,
  output logic            load_pc,
  output logic            datacontrol_en,
  output logic            instr_done,
  output logic            halted,
  output logic            illegal_op,
  output logic            bus_err,
  output logic [3:0]      state_dbg
);

  localparam int BW = $clog2(FETCH_BEATS) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FETCH_BEATS - 1);

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic          zero_q;
  logic          waiting;
  logic          timeout;

  assign waiting = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state    <= ST_FETCH;
            beat_cnt <= '0;
          end
        end
        ST_FETCH: begin
          if (timeout) begin
            state <= ST_HALTED;
          end else if (mem_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_DECODE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DECODE: begin
          zero_q <= zero;
          if (is_mem_operand(operation)) begin
            state <= ST_MEM_RD;
          end else if (operation == OP_STO) begin
            state <= ST_MEM_WR;
          end else if (operation == OP_JMP) begin
            state <= ST_JUMP;
          end else if (operation == OP_SKZ) begin
            state <= zero ? ST_SKIP : ST_DONE;
          end else if (operation == OP_HLT) begin
            state <= ST_HALTED;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_MEM_RD: begin
          if (timeout) begin
            state <= ST_HALTED;
          end else if (mem_ready) begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_DONE;
        ST_MEM_WR: begin
          if (timeout) begin
            state <= ST_HALTED;
          end else if (mem_ready) begin
            state <= ST_DONE;
          end
        end
        ST_JUMP: state <= ST_DONE;
        // One PC increment per beat of the instruction being skipped.
        ST_SKIP: begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt <= '0;
            state    <= ST_DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          beat_cnt <= '0;
          state    <= en ? ST_FETCH : ST_IDLE;
        end
        ST_HALTED: begin
          if (resume) begin
            state    <= ST_FETCH;
            beat_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fetch          = 1'b0;
    alu_en         = 1'b0;
    pc_inc         = 1'b0;
    rd             = 1'b0;
    wr             = 1'b0;
    load_acc       = 1'b0;
    load_ir        = 1'b0;
    load_pc        = 1'b0;
    datacontrol_en = 1'b0;
    instr_done     = 1'b0;
    halted         = 1'b0;
    illegal_op     = 1'b0;
    case (state)
      ST_FETCH: begin
        fetch   = 1'b1;
        rd      = 1'b1;
        load_ir = mem_ready;
        pc_inc  = mem_ready;
      end
      ST_DECODE: begin
        alu_en     = 1'b1;
        load_acc   = (operation == OP_MOV);
        illegal_op = is_illegal(operation);
      end
      ST_MEM_RD: begin
        rd     = 1'b1;
        alu_en = 1'b1;
      end
      ST_EXEC: begin
        alu_en   = 1'b1;
        load_acc = 1'b1;
      end
      ST_MEM_WR: begin
        wr             = 1'b1;
        datacontrol_en = 1'b1;
        alu_en         = 1'b1;
      end
      ST_JUMP:   load_pc    = 1'b1;
      ST_SKIP:   pc_inc     = zero_q;
      ST_DONE:   instr_done = 1'b1;
      ST_HALTED: halted     = 1'b1;
      default: ;
    endcase
  end

  assign bus_err   = timeout;
  assign state_dbg = state;

endmodule
